// File: rtl/btb_update_ctrl_if.sv
// Bus bundle between execute, frontend, BTB update port and btb_update_ctrl.
// The master modport is the environment side; the slave modport is the controller.
`timescale 1ns/1ps

interface btb_update_ctrl_if;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;
  logic        fetch_req;
  logic        btb_update_en;
  logic [31:0] btb_update_pc;
  logic [31:0] btb_update_target;
  logic        btb_update_valid;
  logic        lookup_block;

  modport master (
    output res_valid, res_pc, res_target, res_taken, flush_req, fetch_req,
    input  res_ready, flush_busy, flush_done, btb_update_en, btb_update_pc,
           btb_update_target, btb_update_valid, lookup_block
  );

  modport slave (
    input  res_valid, res_pc, res_target, res_taken, flush_req, fetch_req,
    output res_ready, flush_busy, flush_done, btb_update_en, btb_update_pc,
           btb_update_target, btb_update_valid, lookup_block
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update-port sequencer: resolution FIFO, idle/starvation-forced issue, invalidate sweep.
// Optional macro BTB_NT_CLEAR_EN: enqueue not-taken resolutions as valid=0 (evicting) writes.
`timescale 1ns/1ps

module btb_update_ctrl #(
  parameter int INDEX_BITS   = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic              clk,
  input logic              reset_n,
  btb_update_ctrl_if.slave bus
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_BITS-1:0] STARVE_MAX = CNT_BITS'(STARVE_LIMIT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]            state, state_nxt;
  logic                  flush_pending, pending_nxt;
  logic [INDEX_BITS-1:0] sweep_idx;
  logic [CNT_BITS-1:0]   starve_cnt;
  logic [PTR_BITS:0]     wr_ptr, rd_ptr;

  logic [31:0] fifo_pc     [FIFO_DEPTH];
  logic [31:0] fifo_target [FIFO_DEPTH];
  logic        fifo_taken  [FIFO_DEPTH];

  logic        upd_en, upd_valid, done_q, busy_q;
  logic [31:0] upd_pc, upd_target;

  logic empty, full, accept, push, issue, start_flush, sweep_last;

  function automatic logic [31:0] sweep_pc(input logic [INDEX_BITS-1:0] idx);
    logic [31:0] pc;
    pc = '0;
    pc[INDEX_BITS+1:2] = idx;
    return pc;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                 (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);

  assign bus.res_ready = !full && (state == IDLE) && !flush_pending;
  assign accept        = bus.res_valid && bus.res_ready;

`ifdef BTB_NT_CLEAR_EN
  assign push = accept;
`else
  // Not-taken resolutions complete the handshake but never reach the BTB.
  assign push = accept && bus.res_taken;
`endif

  assign start_flush = (state == IDLE) && flush_pending;
  assign issue       = (state == IDLE) && !flush_pending && !empty &&
                       (!bus.fetch_req || (starve_cnt >= STARVE_MAX));
  assign sweep_last  = &sweep_idx;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    pending_nxt = flush_pending;
    if (state == IDLE) begin
      if (flush_pending) begin
        pending_nxt = 1'b0;
        state_nxt   = FLUSH;
      end else if (bus.flush_req) begin
        pending_nxt = 1'b1;
      end
    end else if (sweep_last) begin
      state_nxt = IDLE;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which slots hold data.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr[PTR_BITS-1:0]]     <= bus.res_pc;
      fifo_target[wr_ptr[PTR_BITS-1:0]] <= bus.res_target;
      fifo_taken[wr_ptr[PTR_BITS-1:0]]  <= bus.res_taken;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      flush_pending <= 1'b0;
      busy_q        <= 1'b0;
      sweep_idx     <= '0;
      starve_cnt    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      state         <= state_nxt;
      flush_pending <= pending_nxt;
      busy_q        <= pending_nxt || (state_nxt == FLUSH);

      if (start_flush)          sweep_idx <= '0;
      else if (state == FLUSH)  sweep_idx <= sweep_idx + 1'b1;

      if (start_flush || issue || empty)                starve_cnt <= '0;
      else if (state == IDLE && starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;

      // No push can coincide with a flush start, since res_ready is low while pending.
      if (start_flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push)  wr_ptr <= wr_ptr + 1'b1;
        if (issue) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_en     <= 1'b0;
      upd_pc     <= '0;
      upd_target <= '0;
      upd_valid  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      upd_en <= 1'b0;
      done_q <= 1'b0;
      if (start_flush) begin
        upd_en     <= 1'b1;
        upd_pc     <= sweep_pc('0);
        upd_target <= '0;
        upd_valid  <= 1'b0;
      end else if (state == FLUSH) begin
        if (sweep_last) begin
          done_q <= 1'b1;
        end else begin
          upd_en     <= 1'b1;
          upd_pc     <= sweep_pc(sweep_idx + 1'b1);
          upd_target <= '0;
          upd_valid  <= 1'b0;
        end
      end else if (issue) begin
        upd_en     <= 1'b1;
        upd_pc     <= fifo_pc[rd_ptr[PTR_BITS-1:0]];
        upd_target <= fifo_target[rd_ptr[PTR_BITS-1:0]];
        upd_valid  <= fifo_taken[rd_ptr[PTR_BITS-1:0]];
      end
    end
  end

  assign bus.btb_update_en     = upd_en;
  assign bus.btb_update_pc     = upd_pc;
  assign bus.btb_update_target = upd_target;
  assign bus.btb_update_valid  = upd_valid;
  assign bus.lookup_block      = upd_en;
  assign bus.flush_done        = done_q;
  assign bus.flush_busy        = busy_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: per-cycle vector table plus hand-written
// flush and reset-during-sweep sequences (INDEX_BITS=4, so the sweep is 16 writes).
`timescale 1ns/1ps

module tb_btb_update_ctrl;

  localparam int INDEX_BITS   = 4;
  localparam int N            = 1 << INDEX_BITS;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  btb_update_ctrl_if bus();

  btb_update_ctrl #(
    .INDEX_BITS  (INDEX_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        fetch;
    logic        e_ready;
    logic        e_en;
    logic [31:0] e_pc;
    logic [31:0] e_tgt;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic fetch, input logic e_ready,
                     input logic e_en, input logic [31:0] e_pc, input logic [31:0] e_tgt,
                     input logic e_valid);
    vec_t r;
    r.v = v; r.pc = pc; r.tgt = tgt; r.tk = tk; r.fetch = fetch;
    r.e_ready = e_ready; r.e_en = e_en; r.e_pc = e_pc; r.e_tgt = e_tgt; r.e_valid = e_valid;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic fetch, input logic flush);
    bus.res_valid  = v;
    bus.res_pc     = pc;
    bus.res_target = tgt;
    bus.res_taken  = tk;
    bus.fetch_req  = fetch;
    bus.flush_req  = flush;
  endtask

  initial begin
    // Single taken resolution: accepted at c0, written in c2.
    add(1, 32'h100, 32'h200, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 32'h100, 32'h200, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Not-taken resolution pc=0x40.
    add(1, 32'h40, 32'h44, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef BTB_NT_CLEAR_EN
    add(0, 0, 0, 0, 0, 1, 1, 32'h40, 32'h44, 0);
`else
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`endif
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // One entry under continuous fetch: 8 blocked cycles then the forced write.
    add(1, 32'h300, 32'h304, 1, 1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 9; c++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 32'h300, 32'h304, 1);
    // Five back-to-back offers under fetch: FIFO fills, drains at the starvation rate.
    for (int k = 0; k < 4; k++)
      add(1, 32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16), 1, 1, 1, 0, 0, 0, 0);
    for (int c = 4; c <= 9; c++) add(1, 32'h1040, 32'h2040, 1, 1, 0, 0, 0, 0, 0);
    add(1, 32'h1040, 32'h2040, 1, 1, 1, 1, 32'h1000, 32'h2000, 1);
    for (int c = 11; c <= 47; c++) begin
      int  k;
      logic en;
      k  = (c - 10) / 9;
      en = ((c - 10) % 9 == 0) && (c <= 46);
      add(0, 0, 0, 0, (c <= 46), (c >= 19), en,
          32'h1000 + 32'(k * 16), 32'h2000 + 32'(k * 16), 1);
    end

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset res_ready", 32'(bus.res_ready), 1);
    check("reset update_en", 32'(bus.btb_update_en), 0);
    check("reset flush_busy", 32'(bus.flush_busy), 0);
    check("reset flush_done", 32'(bus.flush_done), 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].pc, vecs[i].tgt, vecs[i].tk, vecs[i].fetch, 1'b0);
      check($sformatf("v%0d res_ready", i), 32'(bus.res_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d update_en", i), 32'(bus.btb_update_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d lookup_block", i), 32'(bus.lookup_block), 32'(vecs[i].e_en));
      check($sformatf("v%0d flush_busy", i), 32'(bus.flush_busy), 0);
      if (vecs[i].e_en) begin
        check($sformatf("v%0d update_pc", i), bus.btb_update_pc, vecs[i].e_pc);
        check($sformatf("v%0d update_target", i), bus.btb_update_target, vecs[i].e_tgt);
        check($sformatf("v%0d update_valid", i), 32'(bus.btb_update_valid), 32'(vecs[i].e_valid));
      end
    end

    // Flush with three entries queued: entries discarded, 16 sweep writes, done pulse.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 32'h700 + 32'(k * 4), 32'h800, 1, 1, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1);
    check("pre-flush busy", 32'(bus.flush_busy), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("pending busy", 32'(bus.flush_busy), 1);
    check("pending res_ready", 32'(bus.res_ready), 0);
    check("pending update_en", 32'(bus.btb_update_en), 0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check($sformatf("sweep%0d en", i), 32'(bus.btb_update_en), 1);
      check($sformatf("sweep%0d pc", i), bus.btb_update_pc, 32'(i * 4));
      check($sformatf("sweep%0d target", i), bus.btb_update_target, 0);
      check($sformatf("sweep%0d valid", i), 32'(bus.btb_update_valid), 0);
      check($sformatf("sweep%0d res_ready", i), 32'(bus.res_ready), 0);
      check($sformatf("sweep%0d busy", i), 32'(bus.flush_busy), 1);
      check($sformatf("sweep%0d done", i), 32'(bus.flush_done), 0);
    end
    @(negedge clk);
    check("flush_done pulse", 32'(bus.flush_done), 1);
    check("post-sweep en", 32'(bus.btb_update_en), 0);
    check("post-sweep busy", 32'(bus.flush_busy), 0);
    check("post-sweep res_ready", 32'(bus.res_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("discarded%0d en", i), 32'(bus.btb_update_en), 0);
      check($sformatf("discarded%0d done", i), 32'(bus.flush_done), 0);
    end

    // Reset asserted while sweep index 7 is being written.
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("sweep idx7 pc", bus.btb_update_pc, 32'h1C);
    reset_n = 1'b0;
    #1;
    check("midreset en", 32'(bus.btb_update_en), 0);
    check("midreset lookup_block", 32'(bus.lookup_block), 0);
    check("midreset pc", bus.btb_update_pc, 0);
    check("midreset target", bus.btb_update_target, 0);
    check("midreset valid", 32'(bus.btb_update_valid), 0);
    check("midreset busy", 32'(bus.flush_busy), 0);
    check("midreset done", 32'(bus.flush_done), 0);
    check("midreset res_ready", 32'(bus.res_ready), 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("after-reset%0d en", i), 32'(bus.btb_update_en), 0);
      check($sformatf("after-reset%0d done", i), 32'(bus.flush_done), 0);
      check($sformatf("after-reset%0d busy", i), 32'(bus.flush_busy), 0);
    end
    drive(1, 32'h500, 32'h600, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("after-reset accept gap en", 32'(bus.btb_update_en), 0);
    @(negedge clk);
    check("after-reset issue en", 32'(bus.btb_update_en), 1);
    check("after-reset issue pc", bus.btb_update_pc, 32'h500);
    check("after-reset issue target", bus.btb_update_target, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequencing controller for the branch target buffer update port. Buffers branch resolutions from execute in a small FIFO, issues them to the BTB one per cycle when fetch is not using the BTB, and forces issue after a bounded starvation interval. Also runs a full-table invalidate sweep on request, for example on fence.i. Sits between the execute stage, the frontend and the BTB; drives the BTB's update_en/update_pc/update_target/update_valid and tells the frontend when a lookup result is unusable.

## Interface
- INDEX_BITS, 10, BTB index width; table has N = 2^INDEX_BITS entries
- FIFO_DEPTH, 4, resolution FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, max consecutive blocked cycles before a forced issue (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- res_valid  in  1  execute offers a resolved branch
- res_ready  out  1  controller accepts; transfer when res_valid && res_ready
- res_pc  in  32  branch PC
- res_target  in  32  resolved target
- res_taken  in  1  branch taken
- flush_req  in  1  single-cycle invalidate-all request
- flush_busy  out  1  sweep pending or in progress
- flush_done  out  1  one-cycle pulse after the last sweep write
- fetch_req  in  1  frontend performs a BTB lookup this cycle
- btb_update_en  out  1  to BTB update_en
- btb_update_pc  out  32  to BTB update_pc
- btb_update_target  out  32  to BTB update_target
- btb_update_valid  out  1  to BTB update_valid
- lookup_block  out  1  equals btb_update_en; the frontend must treat the BTB hit as 0 this cycle, because the update port steals the index

## Operation
- FSM states: IDLE and FLUSH. flush_pending is a 1-bit latch.
- Enqueue:
  - res_ready = !full && state==IDLE && !flush_pending.
  - An accepted entry stores {pc, target, taken}.
- Issue in IDLE: FIFO non-empty, no flush_pending, and (fetch_req==0 or starve_cnt ≥ STARVE_LIMIT).
  - The head is popped into the output registers.
  - btb_update_en=1 for one cycle, with update_pc=res_pc, update_target=res_target, update_valid=res_taken.
- starve_cnt:
  - Increments in each IDLE cycle where the FIFO is non-empty and no issue occurs.
  - Clears on issue or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Flush:
  - flush_req sets flush_pending; it is ignored while already in FLUSH.
  - In IDLE with flush_pending: discard all FIFO contents, clear starve_cnt and flush_pending, enter FLUSH with sweep index 0. No issue happens that cycle, because flush wins over issue.
  - FLUSH lasts exactly N cycles, regardless of fetch_req. Each cycle: btb_update_en=1, update_pc={0, idx, 2'b00}, update_target=0, update_valid=0.
  - After idx N-1 is written: flush_done=1 for one cycle and return to IDLE.
- flush_busy = flush_pending || state==FLUSH.
- Reset mid-operation: FIFO emptied, sweep abandoned, state IDLE, all outputs 0 except res_ready=1 (combinational). The BTB must be reset separately.

## Timing
- All btb_* outputs, lookup_block, flush_done and flush_busy are registered.
- res_ready is combinational from registered state.
- Accept at edge E0 with fetch_req low in the following cycle: btb_update_en is high in the cycle after edge E1. There is no same-cycle bypass.
- Full FIFO with a simultaneous pop: res_ready stays 0 that cycle, so no push is accepted.
- With fetch_req held high, a head entry issues after exactly STARVE_LIMIT blocked cycles.
- flush_req pulse at edge E0:
  - flush_busy is 1 from E0.
  - Sweep writes occupy the N cycles after E1.
  - flush_done is high in the cycle following the last write.
- Flush during a write already in the output registers: that write completes, and the sweep starts on the next decision.

## Configuration
- BTB_NT_CLEAR_EN defined: not-taken resolutions are enqueued and written with update_valid=0, which evicts the entry.
- BTB_NT_CLEAR_EN undefined: not-taken transfers are accepted (the handshake still completes) but dropped, never entering the FIFO. Every issued write then has update_valid=1.

## Test plan
- Reset release, fetch_req=0, one taken resolution pc=0x100, target=0x200 → one cycle later, exactly one cycle with btb_update_en=1, pc=0x100, target=0x200, valid=1, lookup_block=1.
- fetch_req held 1, one entry queued → issue after 8 blocked cycles. Then 4 entries queued → issued at the starvation rate, in FIFO order.
- 5 back-to-back res_valid with fetch_req=1 → res_ready drops after 4 accepts and rises the cycle after the first pop.
- flush_req with 3 entries queued, INDEX_BITS=4 → entries discarded, 16 consecutive writes with pc=0x0..0x3C and valid=0, flush_done pulse, res_ready=0 throughout.
- Not-taken pc=0x40 → write with valid=0 when the macro is defined; no write when undefined.
- reset_n asserted at sweep index 7 → all outputs 0 immediately. After release: IDLE, FIFO empty, no flush_done.
